// File: rtl/pipe_ripple_adder_n.sv
// Pipelined ripple-carry adder/subtractor, STAGE_BITS resolved per stage, with valid/ready stall.
// Optional signed-overflow output enabled by defining PIPE_ADDER_OVF_EN.
module pipe_ripple_adder_n #(
    parameter int WIDTH      = 16,
    parameter int STAGE_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSTAGE = WIDTH / STAGE_BITS;

    if ((STAGE_BITS < 1) || (WIDTH % STAGE_BITS != 0)) begin : g_bad_width
        $error("pipe_ripple_adder_n: WIDTH must be a non-zero multiple of STAGE_BITS");
    end

    // Stage k holds the full operand word (upper slices act as skew registers)
    // and the sum word with slices 0..k already resolved.
    logic [NSTAGE-1:0] v_q, v_n;
    logic [NSTAGE-1:0] c_q, c_n;
    logic [WIDTH-1:0]  a_q [NSTAGE];
    logic [WIDTH-1:0]  b_q [NSTAGE];
    logic [WIDTH-1:0]  s_q [NSTAGE];
    logic [WIDTH-1:0]  a_n [NSTAGE];
    logic [WIDTH-1:0]  b_n [NSTAGE];
    logic [WIDTH-1:0]  s_n [NSTAGE];

    logic [WIDTH-1:0]  ai, bi, si;
    logic              ci, vi;
    logic [STAGE_BITS:0] part;
    logic              adv;

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_q, ovf_n;
`endif

    assign out_valid = v_q[NSTAGE-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign s         = s_q[NSTAGE-1];
    assign cout      = c_q[NSTAGE-1];

    always_comb begin
        v_n  = '0;
        c_n  = '0;
        ai   = '0;
        bi   = '0;
        si   = '0;
        ci   = 1'b0;
        vi   = 1'b0;
        part = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            a_n[k] = '0;
            b_n[k] = '0;
            s_n[k] = '0;
        end
`ifdef PIPE_ADDER_OVF_EN
        ovf_n = 1'b0;
`endif
        for (int k = 0; k < NSTAGE; k++) begin
            if (k == 0) begin
                ai = a;
                bi = b ^ {WIDTH{sub}};
                ci = sub | cin;
                si = '0;
                vi = in_valid;
            end else begin
                ai = a_q[k-1];
                bi = b_q[k-1];
                ci = c_q[k-1];
                si = s_q[k-1];
                vi = v_q[k-1];
            end
            part = {1'b0, ai[k*STAGE_BITS +: STAGE_BITS]}
                 + {1'b0, bi[k*STAGE_BITS +: STAGE_BITS]}
                 + {{STAGE_BITS{1'b0}}, ci};
            si[k*STAGE_BITS +: STAGE_BITS] = part[STAGE_BITS-1:0];
            a_n[k] = ai;
            b_n[k] = bi;
            s_n[k] = si;
            c_n[k] = part[STAGE_BITS];
            v_n[k] = vi;
`ifdef PIPE_ADDER_OVF_EN
            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            if (k == NSTAGE - 1) begin
                ovf_n = ai[WIDTH-1] ^ bi[WIDTH-1] ^ part[STAGE_BITS-1] ^ part[STAGE_BITS];
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < NSTAGE; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            v_q <= v_n;
            c_q <= c_n;
            for (int k = 0; k < NSTAGE; k++) begin
                a_q[k] <= a_n[k];
                b_q[k] <= b_n[k];
                s_q[k] <= s_n[k];
            end
        end
    end

`ifdef PIPE_ADDER_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_n;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_ripple_adder_n.sv
// Bench for pipe_ripple_adder_n (defaults WIDTH=16, STAGE_BITS=4): directed and random beats
// checked against an arithmetic reference, a valid-occupancy model and an expected-result queue.
module tb_pipe_ripple_adder_n;

    localparam int NS = 4;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout;
`ifdef PIPE_ADDER_OVF_EN
    logic        ovf;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [NS-1:0] mv;
    exp_t        q[$];
    logic        chk_zero = 1'b0;

    pipe_ripple_adder_n #(.WIDTH(16), .STAGE_BITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input logic [15:0] es, input logic ec, input logic eo);
        exp_t e;
        e.s = es;
        e.c = ec;
        e.o = eo;
        return e;
    endfunction

    // Plain 17-bit arithmetic; signed overflow from operand/result signs.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input logic sb);
        logic [16:0] r;
        logic [15:0] yy;
        yy = sb ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {16'b0, (sb ? 1'b1 : ci)};
        return mk(r[15:0], r[16], (x[15] == yy[15]) && (r[15] != x[15]));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                        input logic icin, input logic isub, input logic ior, input exp_t e);
        logic adv_m;
        logic acc;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = icin;
        sub       = isub;
        out_ready = ior;
        #1;
        adv_m = !mv[NS-1] || ior;
        check("out_valid", {31'b0, out_valid}, {31'b0, mv[NS-1]});
        check("in_ready", {31'b0, in_ready}, {31'b0, adv_m});
        if (mv[NS-1]) begin
            check("s", {16'b0, s}, {16'b0, q[0].s});
            check("cout", {31'b0, cout}, {31'b0, q[0].c});
`ifdef PIPE_ADDER_OVF_EN
            check("ovf", {31'b0, ovf}, {31'b0, q[0].o});
`endif
        end else if (chk_zero) begin
            check("idle_s", {16'b0, s}, 32'h0);
            check("idle_cout", {31'b0, cout}, 32'h0);
        end
        acc = iv && adv_m;
        if (mv[NS-1] && ior) void'(q.pop_front());
        if (acc) q.push_back(e);
        @(posedge clk);
        if (adv_m) mv = {mv[NS-2:0], acc};
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);
        check("rst_s", {16'b0, s}, 32'h0);
        check("rst_cout", {31'b0, cout}, 32'h0);
`ifdef PIPE_ADDER_OVF_EN
        check("rst_ovf", {31'b0, ovf}, 32'h0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mv  = '0;
        q.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, '0);
        check("drain_empty", q.size(), 32'h0);
    endtask

    initial begin
        int   nb;
        int   stall;
        logic seen;
        logic ior;
        logic [15:0] ra, rb;
        logic rc, rs, rv;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        mv = '0;
        do_reset();

        // Single beat: latency and quiet outputs beforehand
        chk_zero = 1'b1;
        step(1'b1, 16'h0003, 16'h0001, 1'b0, 1'b0, 1'b1, mk(16'h0004, 1'b0, 1'b0));
        idle(5);
        chk_zero = 1'b0;

        // Carry ripple through every slice
        step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b0));
        step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, mk(16'hFFFF, 1'b1, 1'b0));
        // Subtract, cin ignored
        step(1'b1, 16'h0005, 16'h0003, 1'b1, 1'b1, 1'b1, mk(16'h0002, 1'b1, 1'b0));
        step(1'b1, 16'h0003, 16'h0005, 1'b0, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
        drain();

        // Eight back-to-back beats with a 3-cycle stall at the first result
        nb = 1; stall = 0; seen = 1'b0;
        for (int cyc = 0; cyc < 60 && (nb <= 8 || q.size() > 0); cyc++) begin
            if (mv[NS-1] && !seen) seen = 1'b1;
            ior = !(seen && stall < 3);
            if (!ior) begin
                stall++;
                check("stall_s", {16'b0, s}, 32'h0003);
            end
            rv = (nb <= 8);
            step(rv, 16'(nb), 16'(2 * nb), 1'b0, 1'b0, ior, mk(16'(3 * nb), 1'b0, 1'b0));
            if (rv && (!mv[NS-1] || ior || 1'b1) && q.size() > 0 && q[q.size()-1].s == 16'(3 * nb)) nb++;
        end
        check("stream_beats", nb, 32'd9);
        check("stream_stall", stall, 32'd3);
        drain();

        // Reset with beats in flight
        step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, mk(16'h3333, 1'b0, 1'b0));
        step(1'b1, 16'h0101, 16'h0202, 1'b0, 1'b0, 1'b1, mk(16'h0303, 1'b0, 1'b0));
        step(1'b1, 16'h0011, 16'h0022, 1'b0, 1'b0, 1'b1, mk(16'h0033, 1'b0, 1'b0));
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, '0);
        check("pre_rst_valid", {31'b0, out_valid}, 32'h1);
        do_reset();
        chk_zero = 1'b1;
        idle(3);
        step(1'b1, 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b1, mk(16'h0030, 1'b0, 1'b0));
        idle(5);
        chk_zero = 1'b0;

`ifdef PIPE_ADDER_OVF_EN
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, mk(16'h8000, 1'b0, 1'b1));
        step(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
        step(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, mk(16'h0002, 1'b0, 1'b0));
        drain();
`endif

        // Random traffic with random backpressure
        for (int cyc = 0; cyc < 300; cyc++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rc  = 1'($urandom);
            rs  = 1'($urandom);
            rv  = ($urandom_range(0, 3) != 0);
            ior = ($urandom_range(0, 3) != 0);
            step(rv, ra, rb, rc, rs, ior, model(ra, rb, rc, rs));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
